// File: rtl/mtr_drv_pwm.sv
// Dual-channel H-bridge PWM generator: one shared 2048-clock period counter,
// offset-binary duty per channel, and complementary drives separated by dead time.
module mtr_drv_pwm #(
  parameter int NONOVERLAP = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic               lftPWM1,
  output logic               lftPWM2,
  output logic               rghtPWM1,
  output logic               rghtPWM2,
  output logic               prd_strt
);

  localparam logic [10:0] CNT_LAST  = 11'h7ff;
  localparam logic [10:0] DUTY_ZERO = 11'h400;
  localparam logic [10:0] NO_CNT    = 11'(NONOVERLAP);
  localparam logic [11:0] NO_SUM    = 12'(NONOVERLAP);

  logic [10:0] cnt;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic        lft_hi_p0;
  logic        lft_lo_p0;
  logic        rght_hi_p0;
  logic        rght_lo_p0;
  logic        prd_p0;

  // Signed speed to offset binary: flipping the MSB adds 1024.
  function automatic logic [10:0] to_duty(input logic signed [10:0] spd);
    return {~spd[10], spd[9:0]};
  endfunction

  function automatic logic hi_side(input logic [10:0] c, input logic [10:0] d);
    return (c >= NO_CNT) && (c < d);
  endfunction

  // Sum kept 12 bits wide so a large duty pushes the low-side start past the period.
  function automatic logic lo_side(input logic [10:0] c, input logic [10:0] d);
    return {1'b0, c} >= ({1'b0, d} + NO_SUM);
  endfunction

  // Stage p0: comparisons against the current count and latched duty
  always_comb begin
    lft_hi_p0  = hi_side(cnt, lft_duty);
    lft_lo_p0  = lo_side(cnt, lft_duty);
    rght_hi_p0 = hi_side(cnt, rght_duty);
    rght_lo_p0 = lo_side(cnt, rght_duty);
    prd_p0     = (cnt == CNT_LAST);
  end

  // Stage p1: registered drives; duty latches only at the period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lft_duty  <= DUTY_ZERO;
      rght_duty <= DUTY_ZERO;
      lftPWM1   <= 1'b0;
      lftPWM2   <= 1'b0;
      rghtPWM1  <= 1'b0;
      rghtPWM2  <= 1'b0;
      prd_strt  <= 1'b0;
    end else begin
      cnt <= cnt + 11'd1;
      if (cnt == CNT_LAST) begin
        lft_duty  <= to_duty(lft_spd);
        rght_duty <= to_duty(rght_spd);
      end
      lftPWM1  <= lft_hi_p0;
      lftPWM2  <= lft_lo_p0;
      rghtPWM1 <= rght_hi_p0;
      rghtPWM2 <= rght_lo_p0;
      prd_strt <= prd_p0;
    end
  end

endmodule

// File: doc/mtr_drv_pwm.md
MTR_DRV_PWM -- requirements
Module: mtr_drv_pwm

Interface
REQ-001 The block SHALL have parameter NONOVERLAP, default 32, meaning dead time in clk cycles between complementary outputs; legal range 1..511.
REQ-002 The block SHALL have port clk, input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-004 The block SHALL have port lft_spd, input, 11 bits, signed left motor speed (-1024..+1023) from the PID stage.
REQ-005 The block SHALL have port rght_spd, input, 11 bits, signed right motor speed (-1024..+1023) from the PID stage.
REQ-006 The block SHALL have port lftPWM1, output, 1 bit, left high-side drive.
REQ-007 The block SHALL have port lftPWM2, output, 1 bit, left low-side drive.
REQ-008 The block SHALL have port rghtPWM1, output, 1 bit, right high-side drive.
REQ-009 The block SHALL have port rghtPWM2, output, 1 bit, right low-side drive.
REQ-010 The block SHALL have port prd_strt, output, 1 bit, single-cycle pulse marking the first cycle of each PWM period.

Function
REQ-011 The block SHALL contain one shared 11-bit free-running counter cnt: +1 every clk, wraps 2047->0; period = 2048 clocks.
REQ-012 The block SHALL hold per-channel 11-bit duty registers, loaded only on the edge where cnt==2047, with duty = spd + 11'h400 (spd MSB inverted, offset binary), so that -1024->0, 0->1024, +1023->2047.
REQ-013 Speed-input changes SHALL take effect only at the start of the next period; values between loads are ignored.
REQ-014 Per channel, PWM1 next-state SHALL be (cnt >= NONOVERLAP) AND (cnt < duty).
REQ-015 Per channel, PWM2 next-state SHALL be (cnt >= duty + NONOVERLAP); the sum SHALL be computed 12 bits wide with no wrap, so PWM2 stays low all period when the sum exceeds 2047.
REQ-016 All four PWM outputs SHALL be registered, lagging their comparisons by exactly one clk.
REQ-017 PWM1 and PWM2 of a channel SHALL never both be high; each falling edge SHALL be followed by at least NONOVERLAP low-low cycles before the other output rises, including across the period wrap.
REQ-018 When duty <= NONOVERLAP, PWM1 SHALL stay low for the whole period.
REQ-019 prd_strt SHALL be registered, high exactly during cycles where cnt==0.
REQ-020 Left and right channels SHALL be independent apart from the shared cnt.

Reset
REQ-021 While rst_n is low, cnt SHALL be 0, both duty registers SHALL be 11'h400, and all PWM outputs and prd_strt SHALL be 0.
REQ-022 Assertion of rst_n SHALL force all outputs low immediately (same cycle), including mid-period.
REQ-023 After rst_n deassertion, counting SHALL resume from cnt=0; the first duty load SHALL occur at cnt==2047, with the first period using 50% duty (zero speed).

Verification
REQ-024 The bench SHALL check: reset held, then released with spd=0 -> outputs low during reset; first period lftPWM1 high 992 cycles (cnt 32..1023), lftPWM2 high 992 cycles (cnt 1056..2047), each output lagging by 1 clk.
REQ-025 The bench SHALL check: lft_spd=+1023 -> from the next period, lftPWM1 high 2015 cycles/period and lftPWM2 never high.
REQ-026 The bench SHALL check: rght_spd=-1024 -> rghtPWM1 never high and rghtPWM2 high 2016 cycles/period; left channel unaffected.
REQ-027 The bench SHALL check: lft_spd changed 0 -> +512 at cnt=500 -> current period keeps 992-cycle PWM1; after prd_strt, PWM1 is high 1504 cycles.
REQ-028 The bench SHALL check: rst_n pulsed low at cnt=700 with PWM1 high -> all outputs drop in the same cycle; after release, cnt restarts at 0 with duty 11'h400.
REQ-029 The bench SHALL check: random spd sweep over 50 periods -> assertion that PWM1&PWM2 never overlap, every gap >= NONOVERLAP, and exactly one prd_strt per 2048 clocks.
